io_bank_ccff_shadow: RTL

- Parametrised I/O bank tile with NUM_PADS pads. It generalises the fixed 4-pad right-edge I/O grid.
- Per-pad configuration (direction, polarity inversion) is loaded through the ccff configuration chain into a shift register. It is then atomically committed to a shadow register, so re-shifting never glitches live pads.
- Shift-count checking and sticky error reporting guard against mis-sized bitstreams.
- Sits between fabric inpad/outpad pins and the SoC pad interface; chains via ccff_head/ccff_tail like other tiles.

---
 rtl/io_bank_ccff_shadow.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/io_bank_ccff_shadow.sv
// io_bank_ccff_shadow: parametrised I/O bank tile.
// Per-pad config (dir, inv) is loaded serially through the ccff chain into a
// shift register, then atomically committed to a shadow register that drives
// the live pads. The commit is rejected (sticky error) when the shift count
// since the last commit is not exactly CHAIN_LEN.
// Optional build macro IO_BANK_CCFF_CRC_EN adds a CRC-8 check on the shifted
// stream (ports ccff_crc_exp / cfg_crc).

// Per-pad datapath: isolation, direction steering and polarity inversion.
module io_bank_pad_lane (
  input  logic dir,
  input  logic inv,
  input  logic isol_n,
  input  logic outpad,
  input  logic soc_in,
  output logic soc_dir,
  output logic soc_out,
  output logic inpad
);
  // Isolated pads are forced to input with both data paths parked low.
  always_comb begin
    soc_dir = ~isol_n | dir;
    soc_out = isol_n & ~dir & (outpad ^ inv);
    inpad   = isol_n & dir & (soc_in ^ inv);
  end
endmodule

module io_bank_ccff_shadow #(
  parameter int NUM_PADS = 4
) (
  input  logic                prog_clk,
  input  logic                prog_reset_n,
  input  logic                ccff_head,
  input  logic                ccff_shift_en,
  input  logic                ccff_commit,
  output logic                ccff_tail,
  input  logic                isol_n,
  input  logic [NUM_PADS-1:0] fabric_outpad,
  output logic [NUM_PADS-1:0] fabric_inpad,
  input  logic [NUM_PADS-1:0] gfpga_pad_io_soc_in,
  output logic [NUM_PADS-1:0] gfpga_pad_io_soc_out,
  output logic [NUM_PADS-1:0] gfpga_pad_io_soc_dir,
`ifdef IO_BANK_CCFF_CRC_EN
  input  logic [7:0]          ccff_crc_exp,
  output logic [7:0]          cfg_crc,
`endif
  output logic                cfg_count_ok,
  output logic                cfg_commit_err,
  output logic                cfg_active
);
  localparam int CHAIN_LEN = 2 * NUM_PADS;
  localparam int CNT_W     = $clog2(CHAIN_LEN + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CHAIN_LEN + 1);
  // Shadow reset: every pad an input (dir bit 2i = 1), no inversion.
  localparam logic [CHAIN_LEN-1:0] SHADOW_RST = {NUM_PADS{2'b01}};

  logic [CHAIN_LEN-1:0] sr_q, sr_d;
  logic [CHAIN_LEN-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic                 active_q, active_d;
  logic                 do_shift;
  logic                 commit_ok;

  // Commit wins over shift in the same cycle; the shift is simply dropped.
  assign do_shift = ccff_shift_en & ~ccff_commit;

`ifdef IO_BANK_CCFF_CRC_EN
  logic [7:0] crc_q, crc_d;
  logic       crc_fb;

  // CRC-8 (poly 0x07, MSB-first) over accepted shift bits; cleared by commit.
  always_comb begin
    crc_d  = crc_q;
    crc_fb = crc_q[7] ^ ccff_head;
    if (ccff_commit)
      crc_d = 8'h00;
    else if (do_shift)
      crc_d = {crc_q[6:0], 1'b0} ^ (crc_fb ? 8'h07 : 8'h00);
  end

  // CRC state register.
  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) crc_q <= 8'h00;
    else               crc_q <= crc_d;
  end

  assign cfg_crc   = crc_q;
  assign commit_ok = cfg_count_ok & (crc_q == ccff_crc_exp);
`else
  assign commit_ok = cfg_count_ok;
`endif

  assign cfg_count_ok = (cnt_q == CNT_FULL);

  // Next-state for the chain, shift counter, shadow and status flags.
  always_comb begin
    sr_d     = sr_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    active_d = active_q;
    if (ccff_commit) begin
      cnt_d = '0;
      if (commit_ok) begin
        shadow_d = sr_q;
        active_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end else if (do_shift) begin
      if (CHAIN_LEN > 1)
        sr_d = {sr_q[CHAIN_LEN-2:0], ccff_head};
      if (cnt_q != CNT_SAT)
        cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) begin
      sr_q     <= '0;
      shadow_q <= SHADOW_RST;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      sr_q     <= sr_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      active_q <= active_d;
    end
  end

  assign ccff_tail      = sr_q[CHAIN_LEN-1];
  assign cfg_commit_err = err_q;
  assign cfg_active     = active_q;

  for (genvar i = 0; i < NUM_PADS; i++) begin : g_lane
    io_bank_pad_lane u_lane (
      .dir     (shadow_q[2*i]),
      .inv     (shadow_q[2*i+1]),
      .isol_n  (isol_n),
      .outpad  (fabric_outpad[i]),
      .soc_in  (gfpga_pad_io_soc_in[i]),
      .soc_dir (gfpga_pad_io_soc_dir[i]),
      .soc_out (gfpga_pad_io_soc_out[i]),
      .inpad   (fabric_inpad[i])
    );
  end
endmodule
